sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised single-clock FIFO, successor to the fixed 8-bit FIFO. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. Read mode is selectable at compile time: registered-read or first-word-fall-through. It is the standard buffering element between producer/consumer blocks in the same clock domain.

## Interface
- DATA_W, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_LEVEL, DEPTH-2, almost_full asserted when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- rd_en  in  1  read request
- din  in  DATA_W  write data
- dout  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH×DATA_W register array. Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Write accepted iff wr_en && !full. An accepted write stores din at wr_ptr and increments wr_ptr.
- Read accepted iff rd_en && !empty. An accepted read increments rd_ptr.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Full with wr_en && rd_en: the read is accepted and the write is rejected. overflow sets; count becomes DEPTH-1.
- Empty with wr_en && rd_en: the write is accepted and the read is rejected. underflow sets; count becomes 1.
- count: +1 on write-only, -1 on read-only, otherwise unchanged.
- full, empty, almost_full and almost_empty are registered. They are derived from the next count, so they are exact in the cycle after the update.
- overflow and underflow are sticky and are cleared only by rst.
- Rejected operations do not change the pointers, count or memory.
- Reset values: count=0, pointers=0, dout=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0. Memory contents are not reset.
- Reset mid-operation: all stored data is discarded and the reset values apply on the next edge. A wr_en or rd_en in the same cycle as rst is ignored.

## Timing
- Write-to-empty-deassert latency: 1 cycle (empty falls at the edge that accepts the first write).
- Registered-read mode (default):
  - dout updates at the edge that accepts the read, with mem[rd_ptr]. It is valid from that edge onward.
  - dout holds its value when no read is accepted.
  - Read latency: 1 cycle from rd_en sampled to data.
- Back-to-back writes and reads are sustained at 1 word per cycle each.
- Flags and count change only on clk rising edges; there are no combinational paths from inputs to outputs.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - dout continuously presents the head word mem[rd_ptr] whenever empty=0.
  - An accepted read advances to the next word, visible the following cycle.
  - A word written into an empty FIFO appears on dout the cycle after the write edge.
  - dout is 0 when empty.
- FIFO_FWFT_EN undefined: registered-read mode as described under Timing.
- All flag, count and error behaviour is identical in both modes.

## Test plan
All scenarios use DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
- Reset: rst high for 2 cycles → empty=1, almost_empty=1, full=0, count=0, dout=0, overflow=0, underflow=0.
- Fill and drain: write 0x11..0x18 (8 writes) → count=8, full=1, almost_full from count=6. Then read 8 times → dout sequence 0x11..0x18 in order, empty=1, no error flags.
- Overflow: with the FIFO full, write 0xAA → overflow=1, count stays 8. Drain → 0xAA never appears. overflow stays 1 until rst.
- Underflow: with the FIFO empty, rd_en for 1 cycle → underflow=1, count=0, dout unchanged.
- Simultaneous: with count=4, wr_en=rd_en=1 for 20 cycles with incrementing data → count stays 4, data order preserved across pointer wrap. With count=8, wr_en=rd_en=1 → count=7, overflow=1. With count=0, wr_en=rd_en=1 → count=1, underflow=1.
- FWFT (FIFO_FWFT_EN defined): write 0x5C into an empty FIFO → dout=0x5C one cycle later with no rd_en. A read then gives empty=1 and dout=0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise dout is a registered read.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;

  // Acceptance uses the registered flags, so a full FIFO favours the read and an empty one the write.
  always_comb begin
    wr_acc   = wr_en && !full_q;
    rd_acc   = rd_en && !empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    ovf_d   = ovf_q | (wr_en && full_q);
    udf_d   = udf_q | (rd_en && empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented straight from storage; all selecting state is registered.
  always_comb begin
    dout = empty_q ? '0 : mem_q[rd_ptr_q];
  end
`else
  logic [DATA_W-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = rd_acc ? mem_q[rd_ptr_q] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
